uart_io_ctrl: RTL and testbench
===============================

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

Interface
REQ-001 Parameter TX_DEPTH, default 8, TX FIFO entries; power of two, 2..64.
REQ-002 Parameter RX_DEPTH, default 8, RX FIFO entries; power of two, 2..64.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetq  in  1  asynchronous, active-low reset.
REQ-005 io_rd, io_wr  in  1 each  CPU bus read/write strobes, one cycle each.
REQ-006 io_addr  in  16  one-hot decode; bit 12 = DATA, bit 13 = CTRL/STATUS.
REQ-007 io_dout  in  16  CPU write data.
REQ-008 io_din  out  16  read data; 16'd0 when neither io_addr[12] nor io_addr[13] is set, so it can be OR-combined with other sources.
REQ-009 uart_wr  out  1  one-cycle transmit strobe to the UART.
REQ-010 uart_tx_data  out  8  transmit byte; valid while uart_wr=1.
REQ-011 uart_busy  in  1  UART transmitter busy.
REQ-012 uart_rd  out  1  one-cycle receive-acknowledge strobe to the UART.
REQ-013 uart_valid, uart_rx_data  in  1, 8  UART receive byte available, and that byte.
REQ-014 irq  out  1  level interrupt request.

Function
REQ-015 TX push: io_wr & io_addr[12] writes io_dout[7:0] to the TX FIFO; when the FIFO is full, the byte is dropped and sticky ovf is set.
REQ-016 TX FSM states: IDLE, SEND, GUARD, DRAIN.
- IDLE->SEND when TX FIFO is non-empty and uart_busy=0.
- SEND: uart_wr=1 for exactly one cycle; uart_tx_data = FIFO head; head popped at the end of the cycle; ->GUARD.
- GUARD: one cycle, uart_busy ignored; ->DRAIN.
- DRAIN: ->IDLE when uart_busy=0.
REQ-017 Consecutive uart_wr pulses are at least 3 cycles apart; uart_wr is never asserted while uart_busy=1 in the same cycle.
REQ-018 Simultaneous TX push and pop on a full FIFO: the push is accepted and the count is unchanged; ovf is not set.
REQ-019 RX FSM states: RIDLE, RACK.
- RIDLE->RACK when uart_valid=1 and RX count < RX_DEPTH (count sampled at start of cycle); in that same cycle uart_rx_data is pushed and uart_rd=1 for one cycle.
- RACK: one cycle, uart_valid ignored; ->RIDLE.
REQ-020 When the RX FIFO is full, the FSM stays in RIDLE and does not assert uart_rd, leaving the byte held in the UART (backpressure); no byte is lost in the controller.
REQ-021 DATA read: io_din[7:0] = RX FIFO head combinationally in the same cycle; io_din[15:8] = 0. io_rd & io_addr[12] pops at the clock edge. When the FIFO is empty, the read returns 0 and does not pop.
REQ-022 Simultaneous RX capture and CPU pop: both occur and the count is unchanged.
REQ-023 STATUS read (io_addr[13]) bit assignments:
- bit0 = TX not full
- bit1 = RX not empty
- bit2 = tx_done (TX FIFO empty and TX FSM in IDLE)
- bit3 = ovf
- bit4 = RX full
- bit5 = rx_ie
- bit6 = tx_ie
- others 0
REQ-024 CTRL write (io_wr & io_addr[13]):
- io_dout[0] -> rx_ie
- io_dout[1] -> tx_ie
- io_dout[3]=1 clears ovf
REQ-025 ovf set and clear in the same cycle: set wins.
REQ-026 io_addr[12] and io_addr[13] both set on a read: io_din is the OR of both views. A read side effect (RX pop) occurs only when io_addr[12] is set.
REQ-027 irq = (rx_ie & RX not empty) | (tx_ie & tx_done), registered (one-cycle latency).
REQ-028 FIFO pointers wrap modulo depth; count width is log2(depth)+1.

Reset
REQ-029 While resetq=0, asynchronously:
- both FIFOs empty and pointers 0
- TX FSM = IDLE, RX FSM = RIDLE
- ovf = rx_ie = tx_ie = 0
- uart_wr = uart_rd = irq = 0
- uart_tx_data = 0
REQ-030 Reset asserted mid-transfer abandons all queued data; after release, no uart_wr is issued until a new push occurs.

Verification
REQ-031 Push 0x41, 0x42 with uart_busy modelled 10 cycles after each uart_wr -> two uart_wr pulses carrying 0x41 then 0x42, never overlapping busy; STATUS bit2=1 afterwards.
REQ-032 Push 9 bytes (TX_DEPTH=8) while uart_busy held at 1 -> STATUS bit3=1 and 8 bytes transmitted after busy releases; write CTRL 0x0008 -> bit3=0.
REQ-033 Present uart_valid with bytes 0x10..0x18 while the CPU does not read -> 8 uart_rd pulses, 9th byte not acknowledged, STATUS bit4=1; one DATA read returns 0x10 and the 9th byte is then acknowledged.
REQ-034 DATA read with RX FIFO empty -> io_din=0x0000 and no pointer change; read at an address with neither bit 12 nor bit 13 set -> io_din=0.
REQ-035 Write CTRL 0x0003 with TX idle -> irq=1 the next cycle; push a byte -> irq falls while transmitting and returns when done.
REQ-036 Drop resetq during DRAIN with 3 bytes queued -> outputs zero immediately; after release, no uart_wr and STATUS reads 0x0005.

Source files
------------

// File: rtl/uart_io_ctrl_if.sv
// CPU I/O bus between the processor core and the UART controller.
//   io_rd / io_wr : one-cycle read / write strobes
//   io_addr       : one-hot select, bit 12 = DATA, bit 13 = CTRL/STATUS
//   io_dout       : CPU write data
//   io_din        : read data returned to the CPU (zero when not selected)
interface uart_io_ctrl_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (output io_rd, io_wr, io_addr, io_dout, input  io_din);
    modport slave  (input  io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/uart_io_ctrl.sv
// UART I/O controller: buffers CPU transmit bytes in a TX FIFO and paces them
// into the UART, captures received bytes into an RX FIFO with backpressure,
// and exposes DATA / CTRL-STATUS registers plus a level interrupt.
//   clk, resetq      : clock, asynchronous active-low reset
//   bus (slave)      : CPU I/O bus (io_rd, io_wr, io_addr, io_dout, io_din)
//   uart_wr          : one-cycle transmit strobe, uart_tx_data valid with it
//   uart_busy        : UART transmitter busy
//   uart_rd          : one-cycle receive acknowledge
//   uart_valid       : UART holds a received byte (uart_rx_data)
//   irq              : registered level interrupt

// Byte FIFO; caller only pushes when there is room (or a pop happens the
// same cycle) and only pops when non-empty. DEPTH must be a power of two so
// the pointers wrap on their own.
module uart_io_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wptr_d  = push_i ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_i  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push_i && !pop_i)      count_d = count_q + (AW+1)'(1);
        else if (!push_i && pop_i) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Push into a full FIFO with a simultaneous pop reuses the slot being
    // read this cycle; the head is read before the write lands.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
endmodule

module uart_io_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetq,
    uart_io_ctrl_if.slave        bus,
    output logic                 uart_wr,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_busy,
    output logic                 uart_rd,
    input  logic                 uart_valid,
    input  logic [7:0]           uart_rx_data,
    output logic                 irq
);
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SEND  = 2'd1;
    localparam logic [1:0] TX_GUARD = 2'd2;
    localparam logic [1:0] TX_DRAIN = 2'd3;
    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_ACK   = 1'b1;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [0:0]  rx_state_q, rx_state_d;
    logic        ovf_q, ovf_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;

    logic        sel_data, sel_ctrl, ctrl_wr;
    logic        tx_push_req, tx_push, tx_pop, tx_empty, tx_full, tx_done, ovf_set;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  tx_head, rx_head;
    logic [15:0] status;
    logic        unused_bits;

    assign sel_data = bus.io_addr[12];
    assign sel_ctrl = bus.io_addr[13];
    assign ctrl_wr  = bus.io_wr & sel_ctrl;

    // ---------------- TX path ----------------
    assign tx_push_req = bus.io_wr & sel_data;
    assign tx_pop      = (tx_state_q == TX_SEND);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign ovf_set     = tx_push_req & tx_full & ~tx_pop;

    uart_io_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .resetq(resetq), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(bus.io_dout[7:0]), .rdata_o(tx_head),
        .empty_o(tx_empty), .full_o(tx_full)
    );

    // GUARD gives the UART one cycle to raise busy after the strobe before
    // DRAIN starts trusting it.
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:  if (!tx_empty && !uart_busy) tx_state_d = TX_SEND;
            TX_SEND:  tx_state_d = TX_GUARD;
            TX_GUARD: tx_state_d = TX_DRAIN;
            TX_DRAIN: if (!uart_busy) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    assign uart_wr      = (tx_state_q == TX_SEND);
    assign uart_tx_data = uart_wr ? tx_head : 8'h00;
    assign tx_done      = tx_empty & (tx_state_q == TX_IDLE);

    // ---------------- RX path ----------------
    // Capture only when there is room; otherwise the byte stays in the UART.
    // Gated by resetq so no acknowledge escapes while reset is held.
    assign rx_push = resetq & (rx_state_q == RX_IDLE) & uart_valid & ~rx_full;
    assign rx_pop  = bus.io_rd & sel_data & ~rx_empty;
    assign uart_rd = rx_push;
    assign rx_state_d = rx_push ? RX_ACK : RX_IDLE;

    uart_io_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .resetq(resetq), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(uart_rx_data), .rdata_o(rx_head),
        .empty_o(rx_empty), .full_o(rx_full)
    );

    // ---------------- registers ----------------
    // ovf: a new overflow in the same cycle as a clear wins.
    assign ovf_d   = ovf_set | (ovf_q & ~(ctrl_wr & bus.io_dout[3]));
    assign rx_ie_d = ctrl_wr ? bus.io_dout[0] : rx_ie_q;
    assign tx_ie_d = ctrl_wr ? bus.io_dout[1] : tx_ie_q;
    assign irq_d   = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_done);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            ovf_q      <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            ovf_q      <= ovf_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    // ---------------- read mux ----------------
    assign status = {9'd0, tx_ie_q, rx_ie_q, rx_full, ovf_q, tx_done, ~rx_empty, ~tx_full};

    // Unselected views contribute zero so the result can be OR-ed with
    // other peripherals on the same bus.
    assign bus.io_din = (sel_data ? {8'h00, (rx_empty ? 8'h00 : rx_head)} : 16'h0000)
                      | (sel_ctrl ? status : 16'h0000);

    assign unused_bits = ^{bus.io_addr[15:14], bus.io_addr[11:0], bus.io_dout[15:8]};
endmodule

// File: tb/tb_uart_io_ctrl.sv
module tb_uart_io_ctrl;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic clk = 1'b0;
    logic resetq = 1'b0;
    always #5 clk = ~clk;

    uart_io_ctrl_if bus();
    logic       uart_wr, uart_rd, uart_busy, uart_valid, irq;
    logic [7:0] uart_tx_data, uart_rx_data;

    uart_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk(clk), .resetq(resetq), .bus(bus),
        .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
        .uart_rd(uart_rd), .uart_valid(uart_valid), .uart_rx_data(uart_rx_data),
        .irq(irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // FIFOs are queues; the transmit engine is described by its timing rules:
    // after a strobe it holds for one cycle, then waits for a cycle with busy
    // low, and only from the following cycle may it start the next strobe.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit m_ovf, m_rxie, m_txie, m_irq;
    bit wr_now;      // a strobe is due this cycle
    int hold;        // mandatory hold cycles left after a strobe
    bit wait_busy;   // waiting for busy to drop before re-arming
    bit rx_blk;      // the cycle after an acknowledge ignores uart_valid

    function automatic bit m_idle();
        return !wr_now && hold == 0 && !wait_busy;
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = 16'h0000;
        s[0] = (txq.size() != TXD);
        s[1] = (rxq.size() != 0);
        s[2] = (txq.size() == 0) && m_idle();
        s[3] = m_ovf;
        s[4] = (rxq.size() == RXD);
        s[5] = m_rxie;
        s[6] = m_txie;
        return s;
    endfunction

    function automatic logic [15:0] m_din(input logic [15:0] a);
        logic [15:0] v;
        v = 16'h0000;
        if (a[12] && rxq.size() != 0) v = {8'h00, rxq[0]};
        if (a[13]) v = v | m_status();
        return v;
    endfunction

    function automatic bit rd_exp();
        return resetq && !rx_blk && uart_valid && (rxq.size() < RXD);
    endfunction

    initial begin
        bit tx_ne, push, ctrlw, rd, pop_rx, ovf_set, irq_next;
        forever begin
            @(posedge clk or negedge resetq);
            if (!resetq) begin
                txq.delete(); rxq.delete();
                m_ovf = 0; m_rxie = 0; m_txie = 0; m_irq = 0;
                wr_now = 0; hold = 0; wait_busy = 0; rx_blk = 0;
            end else begin
                irq_next = (m_rxie && rxq.size() != 0) || (m_txie && txq.size() == 0 && m_idle());
                tx_ne   = (txq.size() != 0);
                push    = bus.io_wr && bus.io_addr[12];
                ctrlw   = bus.io_wr && bus.io_addr[13];
                rd      = rd_exp();
                pop_rx  = bus.io_rd && bus.io_addr[12] && rxq.size() != 0;
                ovf_set = push && txq.size() == TXD && !wr_now;
                if (wr_now) void'(txq.pop_front());
                if (push && txq.size() < TXD) txq.push_back(bus.io_dout[7:0]);
                if (wr_now) begin wr_now = 0; hold = 1; wait_busy = 1; end
                else if (hold > 0) hold--;
                else if (wait_busy) begin if (!uart_busy) wait_busy = 0; end
                else if (tx_ne && !uart_busy) wr_now = 1;
                m_ovf = ovf_set || (m_ovf && !(ctrlw && bus.io_dout[3]));
                if (ctrlw) begin m_rxie = bus.io_dout[0]; m_txie = bus.io_dout[1]; end
                if (pop_rx) void'(rxq.pop_front());
                if (rd) rxq.push_back(uart_rx_data);
                rx_blk = rd;
                m_irq  = irq_next;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] wr_log[$];
    int rd_cnt = 0;
    int cyc = 0;
    int last_wr = -100;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("uart_wr", uart_wr, wr_now);
            check("uart_tx_data", uart_tx_data, wr_now ? txq[0] : 8'h00);
            check("uart_rd", uart_rd, rd_exp());
            check("irq", irq, m_irq);
            check("io_din", bus.io_din, m_din(bus.io_addr));
            if (uart_wr === 1'b1) begin
                wr_log.push_back(uart_tx_data);
                check("wr_while_busy", uart_busy, 0);
                check("wr_spacing", (cyc - last_wr) >= 3, 1);
                last_wr = cyc;
            end
            if (uart_rd === 1'b1) rd_cnt++;
        end
    end

    // ---------------- UART responder ----------------
    int busy_len = 10;
    bit force_busy = 0;
    bit rx_en = 0;
    logic [7:0] rx_src[$];

    initial begin
        int cnt, rx_idx;
        bit sw, sr;
        cnt = 0; rx_idx = 0;
        uart_busy = 0; uart_valid = 0; uart_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            sw = uart_wr; sr = uart_rd;
            @(posedge clk); #1;
            if (sr) rx_idx++;
            if (sw) cnt = busy_len; else if (cnt > 0) cnt--;
            uart_busy    = force_busy || cnt > 0;
            uart_valid   = rx_en && rx_idx < rx_src.size();
            uart_rx_data = (rx_idx < rx_src.size()) ? rx_src[rx_idx] : 8'h00;
        end
    end

    // ---------------- CPU stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr_bus();
        bus.io_rd = 0; bus.io_wr = 0; bus.io_addr = 16'h0; bus.io_dout = 16'h0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        bus.io_wr = 1; bus.io_addr = a; bus.io_dout = d;
        tick();
        clr_bus();
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [15:0] v);
        bus.io_rd = 1; bus.io_addr = a;
        @(negedge clk);
        v = bus.io_din;
        @(posedge clk); #1;
        clr_bus();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int base, rbase;
        bit saw;
        clr_bus();
        tick(3);
        check("rst_uart_wr", uart_wr, 0);
        check("rst_uart_rd", uart_rd, 0);
        check("rst_irq", irq, 0);
        check("rst_tx_data", uart_tx_data, 0);
        resetq = 1;
        tick(2);
        cpu_rd(16'h2000, v); check("status_after_reset", v, 16'h0005);

        // two bytes, busy 10 cycles after each strobe
        base = wr_log.size();
        cpu_wr(16'h1000, 16'h0041);
        cpu_wr(16'h1000, 16'h0042);
        tick(40);
        check("tx2_count", wr_log.size() - base, 2);
        check("tx2_byte0", wr_log[base], 8'h41);
        check("tx2_byte1", wr_log[base+1], 8'h42);
        cpu_rd(16'h2000, v); check("tx2_status_done", v, 16'h0005);

        // overflow with busy held
        force_busy = 1; tick(2);
        base = wr_log.size();
        for (int i = 0; i < 9; i++) cpu_wr(16'h1000, 16'h00A0 + 16'(i));
        cpu_rd(16'h2000, v); check("ovf_status", v, 16'h0008);
        check("ovf_no_tx_while_busy", wr_log.size() - base, 0);
        force_busy = 0;
        tick(150);
        check("ovf_tx_count", wr_log.size() - base, 8);
        for (int i = 0; i < 8; i++) check("ovf_tx_byte", wr_log[base+i], 8'hA0 + 8'(i));
        cpu_rd(16'h2000, v); check("ovf_status_after", v, 16'h000D);
        cpu_wr(16'h2000, 16'h0008);
        cpu_rd(16'h2000, v); check("ovf_cleared", v, 16'h0005);

        // RX backpressure
        rbase = rd_cnt;
        for (int i = 0; i < 9; i++) rx_src.push_back(8'h10 + 8'(i));
        rx_en = 1;
        tick(30);
        check("rx_ack_count8", rd_cnt - rbase, 8);
        cpu_rd(16'h2000, v); check("rx_full_status", v, 16'h0017);
        cpu_rd(16'h1000, v); check("rx_first_byte", v, 16'h0010);
        tick(4);
        check("rx_ack_count9", rd_cnt - rbase, 9);
        for (int i = 1; i < 9; i++) begin
            cpu_rd(16'h1000, v); check("rx_drain_byte", v, 16'h0010 + 16'(i));
        end

        // empty reads and unselected addresses
        cpu_rd(16'h1000, v); check("rx_empty_read", v, 16'h0000);
        cpu_rd(16'h2000, v); check("rx_empty_status", v, 16'h0005);
        cpu_rd(16'h0001, v); check("unsel_read1", v, 16'h0000);
        cpu_rd(16'h8000, v); check("unsel_read2", v, 16'h0000);
        rx_src.push_back(8'h5A);
        tick(4);
        cpu_rd(16'h3000, v); check("both_views_or", v, 16'h005F);
        cpu_rd(16'h2000, v); check("both_views_popped", v, 16'h0005);

        // interrupt behaviour
        cpu_wr(16'h2000, 16'h0003);
        check("irq_not_yet", irq, 0);
        tick(1);
        check("irq_raised", irq, 1);
        base = wr_log.size();
        cpu_wr(16'h1000, 16'h0077);
        saw = 0;
        for (int k = 0; k < 10 && !saw; k++) begin tick(1); if (irq === 1'b0) saw = 1; end
        check("irq_fell_tx", saw, 1);
        saw = 0;
        for (int k = 0; k < 60 && !saw; k++) begin tick(1); if (irq === 1'b1) saw = 1; end
        check("irq_back_done", saw, 1);
        check("irq_tx_byte", wr_log[base], 8'h77);
        cpu_wr(16'h2000, 16'h0000);
        tick(2);

        // reset during drain with bytes queued
        base = wr_log.size();
        for (int i = 0; i < 4; i++) cpu_wr(16'h1000, 16'h00C1 + 16'(i));
        tick(3);
        check("drain_one_sent", wr_log.size() - base, 1);
        resetq = 0;
        #1;
        check("rstmid_uart_wr", uart_wr, 0);
        check("rstmid_tx_data", uart_tx_data, 0);
        check("rstmid_irq", irq, 0);
        check("rstmid_uart_rd", uart_rd, 0);
        tick(3);
        resetq = 1;
        base = wr_log.size();
        tick(30);
        check("rstmid_no_tx", wr_log.size() - base, 0);
        cpu_rd(16'h2000, v); check("rstmid_status", v, 16'h0005);

        // randomized traffic checked by the model every cycle
        rx_en = 1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            busy_len = $urandom_range(0, 12);
            if ($urandom_range(0, 99) < 8 && rx_src.size() < 100000) rx_src.push_back(8'($urandom));
            r = $urandom_range(0, 99);
            if (r < 25)      cpu_wr(16'h1000, 16'($urandom));
            else if (r < 45) cpu_rd(16'h1000, v);
            else if (r < 55) cpu_rd(16'h2000, v);
            else if (r < 60) cpu_wr(16'h2000, 16'($urandom));
            else if (r < 66) cpu_rd(16'($urandom), v);
            else if (r < 69) cpu_wr(16'($urandom), 16'($urandom));
            else             tick(1);
        end
        rx_en = 0;
        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
